// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and queues
// {pc, instr} pairs in a small FIFO toward decode; a redirect reloads the PC and flushes the FIFO.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [31:0]   r_pc;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
   logic [31:0]   r_fifo_instr [FIFO_DEPTH];
   logic [31:0]   r_last_pc;
   logic [31:0]   r_last_instr;

   logic          w_nonempty;
   logic          w_pop;
   logic          w_push;
   logic          w_unused_bits;

   assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

   assign imem_addr  = r_pc;
   assign w_nonempty = (r_count != '0);
   // Redirect masks the handshake in the same cycle, so nothing stale is consumed.
   assign out_valid  = w_nonempty & ~redirect_valid;
   assign w_pop      = out_valid & out_ready;
   assign w_push     = ~redirect_valid & ((r_count < DEPTH_C) | w_pop);

   assign out_pc    = w_nonempty ? r_fifo_pc[r_rd]    : r_last_pc;
   assign out_instr = w_nonempty ? r_fifo_instr[r_rd] : r_last_instr;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr]    <= r_pc;
         r_fifo_instr[r_wr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_count      <= '0;
         r_rd         <= '0;
         r_wr         <= '0;
         r_last_pc    <= '0;
         r_last_instr <= '0;
      end else if (redirect_valid) begin
         r_pc    <= {redirect_pc[31:2], 2'b00};
         r_count <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
      end else begin
         if (w_push) begin
            r_pc <= r_pc + 32'd4;
            r_wr <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd         <= r_rd + AW'(1);
            r_last_pc    <= r_fifo_pc[r_rd];
            r_last_instr <= r_fifo_instr[r_rd];
         end
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule
